fir_decimator: RTL and testbench
================================

# fir_decimator

Decimating FIR engine between the UART capture path and the UART return path. Reads 16-bit signed samples from the sample RAM that the receive side fills, computes `TAPS`-tap FIR outputs at one output per `DECIM` input samples, and writes 40-bit results into the result RAM. The transmit side streams that result RAM back to the host. One MAC per cycle, coefficients held in an internal register file loaded from the host side.

## Interface
- `TAPS`, 32: number of coefficients; range 1..32.
- `DECIM`, 16: input samples per output.
- `CLOCK_50`  in  1  system clock; all logic on rising edge.
- `RST_N`  in  1  reset, asynchronous, active-low.
- `START`  in  1  one-cycle pulse that begins a run; sampled only in IDLE.
- `N_OUT`  in  11  number of outputs to produce, 0..1024; latched on START.
- `COEF_WE`  in  1  coefficient write strobe; ignored while BUSY.
- `COEF_ADDR`  in  5  coefficient index k; writes with k ≥ TAPS are ignored.
- `COEF_DATA`  in  16  signed coefficient c[k].
- `BUSY`  out  1  high from the cycle after an accepted START until DONE.
- `DONE`  out  1  one-cycle pulse at the end of a run.
- `smp_rd_en`  out  1  sample RAM read enable.
- `smp_rd_address`  out  14  sample index.
- `smp_rd_data`  in  16  signed sample; valid the cycle after `smp_rd_en`.
- `res_wr_en`  out  1  result RAM write strobe, one cycle per output.
- `res_wr_address`  out  10  output index n.
- `res_wr_data`  out  40  signed y[n].

## Operation
- Function: y[n] = Σ_{k=0}^{TAPS-1} c[k]·x[n·DECIM − k], for n = 0..N_OUT−1. A sample x[i] with i < 0 counts as 0.
- Arithmetic:
  - 16×16 signed product is 32 bits.
  - The accumulator is 40-bit signed; each product is sign-extended before the add.
  - No saturation. The worst case is 32·2^30 = 2^35, which fits.
- Reset (`RST_N` low) clears:
  - FSM to IDLE.
  - `BUSY`, `DONE`, `smp_rd_en`, `res_wr_en` to 0.
  - `smp_rd_address`, `res_wr_address`, `res_wr_data` to 0.
  - Accumulator, pipeline registers and all coefficients to 0.
  - Asserting reset mid-run aborts the run with no further writes and no DONE.
- FSM states:
  - IDLE: waits for START. START with N_OUT=0 goes to FINISH directly. Any other START goes to FETCH with n=0, k=0 and the accumulator cleared.
  - FETCH: one cycle per tap k = 0..TAPS−1. Each cycle asserts `smp_rd_en` with address n·DECIM−k (14-bit). When n·DECIM−k < 0, `smp_rd_en` stays 0 and a zero-valid flag travels down the pipeline so that product contributes 0. After k = TAPS−1, go to DRAIN.
  - DRAIN: 2 cycles, letting the RAM-data and product stages retire into the accumulator. Then go to WRITE.
  - WRITE: one cycle.
    - Asserts `res_wr_en` with address n and the accumulator value.
    - Clears the accumulator.
    - If n = N_OUT−1, go to FINISH; otherwise increment n and go to FETCH with k=0.
  - FINISH: pulses `DONE`, drops `BUSY`, returns to IDLE.
- Pipeline: RAM read (1 cycle) → product register → accumulate. Each MAC stage carries a valid bit.
- START while BUSY is ignored. COEF_WE while BUSY is ignored. COEF_WE in IDLE takes effect the next cycle. If COEF_WE and START arrive in the same IDLE cycle, the coefficient write lands first and is used by the run.
- Outside WRITE, `res_wr_data` holds the last written value and `res_wr_address` holds n.

## Timing
- Cycle S: START accepted. S+1: BUSY=1 and the first FETCH cycle (k=0).
- Per output: TAPS fetch cycles + 2 drain + 1 write, i.e. TAPS+3 cycles (35 at defaults).
- The first `res_wr_en` is at S+TAPS+3. Output n is written at S+(n+1)(TAPS+3).
- DONE is at S+N_OUT·(TAPS+3)+1, the same cycle BUSY falls. A new START is accepted from the following cycle.
- With N_OUT=0: DONE at S+1, BUSY high for that one cycle only, and no RAM accesses.
- `smp_rd_en` never asserts outside FETCH. `res_wr_en` is exactly one cycle per output.

## Test plan
- Pass-through: c[0]=1, all other coefficients 0, x[i]=i, N_OUT=4 → writes y = 0, 16, 32, 48 at addresses 0..3. First write at S+35, DONE at S+141.
- Boxcar with edge zeros: all c[k]=1, x[i]=1, N_OUT=3 → y[0]=1, y[1]=17, y[2]=32. For n=0 only one `smp_rd_en` is asserted.
- Width extremes: all c[k]=−32768, all x=−32768, N_OUT=3 → y[2]=0x0800000000 (2^35) with no wrap.
- Coefficient writes are checked in two steps:
  - COEF_WE with c[0]=5 while BUSY is ignored; the next run uses the old value.
  - COEF_WE with COEF_ADDR=5 ≥ TAPS at TAPS=4 is dropped.
- Control corners:
  - N_OUT=0 → DONE at S+1 with no RAM strobes.
  - A second START while BUSY produces no extra outputs.
  - N_OUT=1024 writes addresses 0..1023, with the last read at address 16368.
- Reset mid-run: drop RST_N at S+50 with N_OUT=4 → all outputs 0 immediately, no further writes, no DONE. A later START runs cleanly with coefficients all 0, producing y = 0.

Source files
------------

// File: rtl/fir_decimator_if.sv
// fir_decimator_if: sample-RAM read port and result-RAM write port
// seen by the FIR engine (master) and the RAMs (slave).
interface fir_decimator_if;
    logic        smp_rd_en;
    logic [13:0] smp_rd_address;
    logic [15:0] smp_rd_data;
    logic        res_wr_en;
    logic [9:0]  res_wr_address;
    logic [39:0] res_wr_data;

    modport master (
        output smp_rd_en, smp_rd_address,
        input  smp_rd_data,
        output res_wr_en, res_wr_address, res_wr_data
    );

    modport slave (
        input  smp_rd_en, smp_rd_address,
        output smp_rd_data,
        input  res_wr_en, res_wr_address, res_wr_data
    );
endinterface

// File: rtl/fir_decimator.sv
// fir_decimator: decimating FIR, one MAC per cycle over the sample RAM,
// one 40-bit result per DECIM input samples into the result RAM.
module fir_decimator #(
    parameter int TAPS  = 32,
    parameter int DECIM = 16
) (
    input  logic        CLOCK_50,
    input  logic        RST_N,
    input  logic        START,
    input  logic [10:0] N_OUT,
    input  logic        COEF_WE,
    input  logic [4:0]  COEF_ADDR,
    input  logic [15:0] COEF_DATA,
    output logic        BUSY,
    output logic        DONE,
    fir_decimator_if.master ram
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DRAIN, S_WRITE, S_FINISH
    } state_t;

    state_t state_q, state_d;
    logic [4:0]  k_q, k_d;
    logic [9:0]  n_q, n_d;
    logic [10:0] nout_q, nout_d;
    logic        drn_q, drn_d;
    logic signed [39:0] acc_q, acc_d;
    logic signed [39:0] res_q, res_d;

    logic signed [15:0] coef_q [32];
    logic        v1_q, z1_q, v2_q;
    logic signed [15:0] c1_q;
    logic signed [31:0] prod_q;

    logic [14:0] base_w;
    logic        neg_w;
    logic        fetch_w;
    logic        last_w;
    logic signed [31:0] mul_w;

    assign base_w  = 15'(n_q) * 15'(DECIM);
    assign neg_w   = 15'(k_q) > base_w;
    assign fetch_w = state_q == S_FETCH;
    assign last_w  = n_q == 10'(nout_q - 11'd1);
    assign mul_w   = c1_q * $signed(ram.smp_rd_data);

    assign BUSY               = state_q != S_IDLE;
    assign DONE               = state_q == S_FINISH;
    assign ram.smp_rd_en      = fetch_w && !neg_w;
    assign ram.smp_rd_address = 14'(base_w - 15'(k_q));
    assign ram.res_wr_en      = state_q == S_WRITE;
    assign ram.res_wr_address = n_q;
    assign ram.res_wr_data    = (state_q == S_WRITE) ? acc_q : res_q;

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        n_d     = n_q;
        nout_d  = nout_q;
        drn_d   = drn_q;
        acc_d   = acc_q;
        res_d   = res_q;
        if (v2_q)
            acc_d = acc_q + {{8{prod_q[31]}}, prod_q};
        unique case (state_q)
            S_IDLE: begin
                if (START) begin
                    nout_d  = N_OUT;
                    n_d     = '0;
                    k_d     = '0;
                    acc_d   = '0;
                    state_d = (N_OUT == 11'd0) ? S_FINISH : S_FETCH;
                end
            end
            S_FETCH: begin
                if (k_q == 5'(TAPS - 1)) begin
                    k_d     = '0;
                    drn_d   = 1'b0;
                    state_d = S_DRAIN;
                end else begin
                    k_d = k_q + 5'd1;
                end
            end
            S_DRAIN: begin
                drn_d = 1'b1;
                if (drn_q)
                    state_d = S_WRITE;
            end
            S_WRITE: begin
                res_d = acc_q;
                acc_d = '0;
                if (last_w) begin
                    state_d = S_FINISH;
                end else begin
                    n_d     = n_q + 10'd1;
                    state_d = S_FETCH;
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            n_q     <= '0;
            nout_q  <= '0;
            drn_q   <= 1'b0;
            acc_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            n_q     <= n_d;
            nout_q  <= nout_d;
            drn_q   <= drn_d;
            acc_q   <= acc_d;
            res_q   <= res_d;
        end
    end

    // MAC pipeline: RAM data and coefficient -> product -> accumulator
    always_ff @(posedge CLOCK_50 or negedge RST_N) begin
        if (!RST_N) begin
            v1_q   <= 1'b0;
            z1_q   <= 1'b0;
            v2_q   <= 1'b0;
            c1_q   <= '0;
            prod_q <= '0;
            for (int i = 0; i < 32; i++)
                coef_q[i] <= '0;
        end else begin
            v1_q   <= fetch_w;
            z1_q   <= neg_w;
            c1_q   <= coef_q[k_q];
            v2_q   <= v1_q;
            prod_q <= (v1_q && !z1_q) ? mul_w : '0;
            if (state_q == S_IDLE && COEF_WE &&
                6'(COEF_ADDR) < 6'(TAPS))
                coef_q[COEF_ADDR] <= COEF_DATA;
        end
    end

endmodule

// File: tb/tb_fir_decimator.sv
// tb_fir_decimator: directed runs of the decimating FIR against a
// plain-arithmetic convolution model and a timed result scoreboard.
module tb_fir_decimator;
    localparam int T = 32;
    localparam int D = 16;
    localparam int P = T + 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        start = 1'b0, coef_we = 1'b0;
    logic [10:0] n_out = '0;
    logic [4:0]  coef_addr = '0;
    logic [15:0] coef_data = '0;
    logic        busy, done;

    logic        start4 = 1'b0, coef_we4 = 1'b0;
    logic [10:0] n_out4 = '0;
    logic [4:0]  coef_addr4 = '0;
    logic [15:0] coef_data4 = '0;
    logic        busy4, done4;

    fir_decimator_if bus ();
    fir_decimator_if bus4 ();

    fir_decimator #(.TAPS(T), .DECIM(D)) dut (
        .CLOCK_50(clk), .RST_N(rst_n), .START(start), .N_OUT(n_out),
        .COEF_WE(coef_we), .COEF_ADDR(coef_addr), .COEF_DATA(coef_data),
        .BUSY(busy), .DONE(done), .ram(bus)
    );

    fir_decimator #(.TAPS(4), .DECIM(D)) dut4 (
        .CLOCK_50(clk), .RST_N(rst_n), .START(start4), .N_OUT(n_out4),
        .COEF_WE(coef_we4), .COEF_ADDR(coef_addr4), .COEF_DATA(coef_data4),
        .BUSY(busy4), .DONE(done4), .ram(bus4)
    );

    logic signed [15:0] mem [16384];
    logic signed [15:0] mc [32];

    always @(posedge clk) begin
        if (bus.smp_rd_en)  bus.smp_rd_data  <= mem[bus.smp_rd_address];
        if (bus4.smp_rd_en) bus4.smp_rd_data <= mem[bus4.smp_rd_address];
    end

    int cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    typedef struct {
        int          cyc;
        int          addr;
        logic [39:0] data;
    } exp_t;

    exp_t wq[$];
    int   dq[$];
    int   errors = 0;
    int   checks = 0;
    int   rd_cnt = 0;
    int   rd_max = 0;
    logic [39:0] last_wr = '0;
    logic [39:0] got4 [4];
    int   wr4_cnt = 0;

    function automatic longint model_y(input int n, input int taps);
        longint s = 0;
        for (int k = 0; k < taps; k++) begin
            int idx = n * D - k;
            if (idx >= 0)
                s += longint'(mc[k]) * longint'(mem[idx]);
        end
        return s;
    endfunction

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // Every result write and DONE pulse is matched against the expected queue.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.smp_rd_en) begin
                rd_cnt++;
                if (int'(bus.smp_rd_address) > rd_max)
                    rd_max = int'(bus.smp_rd_address);
            end
            if (bus4.res_wr_en) begin
                got4[bus4.res_wr_address[1:0]] = bus4.res_wr_data;
                wr4_cnt++;
            end
            if (bus.res_wr_en) begin
                checks++;
                last_wr = bus.res_wr_data;
                if (wq.size() == 0) begin
                    errors++;
                    $display("FAIL wr_unexpected: addr %0d data %0h cyc %0d",
                             bus.res_wr_address, bus.res_wr_data, cyc);
                end else begin
                    e = wq.pop_front();
                    if (bus.res_wr_address !== 10'(e.addr) ||
                        bus.res_wr_data !== e.data || cyc != e.cyc) begin
                        errors++;
                        $display("FAIL wr: got a=%0d d=%0h c=%0d expected a=%0d d=%0h c=%0d",
                                 bus.res_wr_address, bus.res_wr_data, cyc,
                                 e.addr, e.data, e.cyc);
                    end
                end
            end
            if (done) begin
                checks++;
                if (dq.size() == 0) begin
                    errors++;
                    $display("FAIL done_unexpected: cyc %0d", cyc);
                end else if (dq[0] != cyc) begin
                    errors++;
                    $display("FAIL done_cyc: got %0d expected %0d", cyc, dq[0]);
                    void'(dq.pop_front());
                end else begin
                    void'(dq.pop_front());
                end
            end
        end
    end

    task automatic wcoef(input int a, input int v, input bit upd);
        coef_we   = 1'b1;
        coef_addr = 5'(a);
        coef_data = 16'(v);
        @(negedge clk);
        coef_we = 1'b0;
        if (upd) mc[a] = 16'(v);
    endtask

    task automatic set_coefs(input int v0, input int rest);
        for (int k = 0; k < T; k++)
            wcoef(k, (k == 0) ? v0 : rest, 1'b1);
    endtask

    task automatic run(input int nout, output int s);
        exp_t e;
        start = 1'b1;
        n_out = 11'(nout);
        s = cyc;
        for (int n = 0; n < nout; n++) begin
            e.cyc  = s + (n + 1) * P;
            e.addr = n;
            e.data = 40'(model_y(n, T));
            wq.push_back(e);
        end
        dq.push_back(s + nout * P + 1);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string nm, input int budget, output int dc);
        int c = 0;
        while (!done && c < budget) begin
            @(negedge clk);
            c++;
        end
        dc = cyc;
        if (!done) begin
            errors++;
            checks++;
            $display("FAIL %s_timeout: got no DONE expected DONE within %0d", nm, budget);
        end
        @(negedge clk);
    endtask

    task automatic reset_outputs(input string nm);
        chk({nm, "_busy"}, 64'(busy), 0);
        chk({nm, "_done"}, 64'(done), 0);
        chk({nm, "_rd_en"}, 64'(bus.smp_rd_en), 0);
        chk({nm, "_wr_en"}, 64'(bus.res_wr_en), 0);
        chk({nm, "_wr_addr"}, 64'(bus.res_wr_address), 0);
        chk({nm, "_wr_data"}, 64'(bus.res_wr_data), 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s, dc;
        for (int k = 0; k < 32; k++) mc[k] = '0;
        repeat (3) @(negedge clk);
        reset_outputs("reset");
        chk("reset_rd_addr", 64'(bus.smp_rd_address), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Pass-through
        for (int i = 0; i < 16384; i++) mem[i] = 16'(i);
        wcoef(0, 1, 1'b1);
        chk("pt_model1", 64'(model_y(1, T)), 64'(16));
        chk("pt_model3", 64'(model_y(3, T)), 64'(48));
        run(4, s);
        wait_done("pt", 200, dc);
        chk("pt_done_at", 64'(dc - s), 64'(141));

        // Boxcar with leading zeros
        set_coefs(1, 1);
        for (int i = 0; i < 16384; i++) mem[i] = 16'sd1;
        chk("box_model0", 64'(model_y(0, T)), 64'(1));
        chk("box_model1", 64'(model_y(1, T)), 64'(17));
        chk("box_model2", 64'(model_y(2, T)), 64'(32));
        rd_cnt = 0;
        run(3, s);
        wait_done("box", 200, dc);
        chk("box_reads", 64'(rd_cnt), 64'(1 + 17 + 32));

        // Width extremes
        set_coefs(-32768, -32768);
        for (int i = 0; i < 16384; i++) mem[i] = -16'sd32768;
        chk("ext_model2", 64'(model_y(2, T)), 64'h8_0000_0000);
        run(3, s);
        wait_done("ext", 200, dc);
        chk("ext_y2", 64'(last_wr), 64'h08_0000_0000);

        // Coefficient write and second START while busy are ignored
        set_coefs(1, 0);
        for (int i = 0; i < 16384; i++) mem[i] = 16'(i);
        run(2, s);
        repeat (5) @(negedge clk);
        wcoef(0, 5, 1'b0);
        start = 1'b1;
        n_out = 11'd5;
        @(negedge clk);
        start = 1'b0;
        wait_done("busy", 200, dc);
        chk("busy_model1", 64'(model_y(1, T)), 64'(16));
        run(2, s);
        wait_done("busy2", 200, dc);
        chk("busy2_y1", 64'(last_wr), 64'(16));

        // N_OUT = 0
        rd_cnt = 0;
        run(0, s);
        chk("zero_busy", 64'(busy), 1);
        wait_done("zero", 10, dc);
        chk("zero_done_at", 64'(dc - s), 64'(1));
        chk("zero_reads", 64'(rd_cnt), 0);
        chk("zero_busy_after", 64'(busy), 0);

        // N_OUT = 1024 with c[0]=1, c[1]=-2
        wcoef(1, -2, 1'b1);
        chk("full_model5", 64'(model_y(5, T)), 64'(-78));
        rd_cnt = 0;
        rd_max = 0;
        run(1024, s);
        wait_done("full", 1024 * P + 20, dc);
        chk("full_rd_max", 64'(rd_max), 64'(16368));
        chk("full_reads", 64'(rd_cnt), 64'(1 + 17 + 32 * 1022));

        // Reset in the middle of a run
        run(4, s);
        while (cyc < s + 50) @(negedge clk);
        rst_n = 1'b0;
        wq.delete();
        dq.delete();
        for (int k = 0; k < 32; k++) mc[k] = '0;
        #1;
        reset_outputs("midrst");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_no_done", 64'(dq.size()), 0);
        run(2, s);
        wait_done("postrst", 200, dc);
        chk("postrst_y1", 64'(last_wr), 0);

        // Four-tap instance: writes at COEF_ADDR >= TAPS are dropped
        for (int k = 0; k < 6; k++) begin
            coef_we4   = 1'b1;
            coef_addr4 = 5'(k);
            coef_data4 = (k < 4) ? 16'd1 : 16'd100;
            @(negedge clk);
        end
        coef_we4 = 1'b0;
        for (int i = 0; i < 16384; i++) mem[i] = 16'sd1;
        start4 = 1'b1;
        n_out4 = 11'd2;
        @(negedge clk);
        start4 = 1'b0;
        chk("t4_busy", 64'(busy4), 1);
        for (int c = 0; c < 100 && !done4; c++) @(negedge clk);
        chk("t4_done", 64'(done4), 1);
        chk("t4_writes", 64'(wr4_cnt), 2);
        chk("t4_y0", 64'(got4[0]), 64'(1));
        chk("t4_y1", 64'(got4[1]), 64'(4));

        repeat (3) @(negedge clk);
        chk("wq_empty", 64'(wq.size()), 0);
        chk("dq_empty", 64'(dq.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
